// File: rtl/md_sequencer.sv
// Multicycle mul/div sequencer for the X stage: detects mul/div, starts the shared
// multdiv unit, stalls the pipeline until it answers, then issues one writeback.
//
// state | meaning
// IDLE  | waiting for a mul/div in X
// START | operands latched, one-cycle start pulse to multdiv
// BUSY  | waiting for md_resultRDY or timeout, pipeline stalled
// DONE  | one-cycle writeback of result or status code
module md_sequencer #(
   parameter int TIMEOUT      = 40,
   parameter int CNT_W        = 6,
   parameter int MUL_EXC_CODE = 4,
   parameter int DIV_EXC_CODE = 5,
   parameter int STATUS_REG   = 30
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [4:0]  ex_opcode,
   input  logic [4:0]  ex_aluop,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_operandA,
   input  logic [31:0] ex_operandB,
   input  logic        flush,
   input  logic        md_resultRDY,
   input  logic        md_exception,
   input  logic [31:0] md_result,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   output logic        stall,
   output logic        busy,
   output logic        wb_valid,
   output logic [4:0]  wb_reg,
   output logic [31:0] wb_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [4:0]  ALU_MUL  = 5'b00110;
   localparam logic [4:0]  ALU_DIV  = 5'b00111;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       rd_q;
   logic             is_div_q;
   logic             is_md;
   logic             load_op;
   logic             capture;
   logic             timeout_hit;
   logic [31:0]      exc_code;

   assign is_md    = ex_valid && (ex_opcode == 5'b00000) &&
                     ((ex_aluop == ALU_MUL) || (ex_aluop == ALU_DIV));
   assign exc_code = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);

   always_comb begin
      state_nx    = state;
      load_op     = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (is_md && !flush) begin
               state_nx = S_START;
               load_op  = 1'b1;
            end
         end
         S_START: state_nx = S_BUSY;
         S_BUSY: begin
            if (md_resultRDY) begin
               state_nx = S_DONE;
               capture  = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nx    = S_DONE;
               timeout_hit = 1'b1;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      // A flush kills the instruction being sequenced, whatever multdiv reports.
      if (flush && (state != S_IDLE)) begin
         state_nx    = S_IDLE;
         capture     = 1'b0;
         timeout_hit = 1'b0;
      end
   end

   always_comb begin
      stall    = ((state == S_IDLE) && is_md && !flush) ||
                 (state == S_START) || (state == S_BUSY);
      busy     = (state != S_IDLE);
      wb_valid = (state == S_DONE) && !flush;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         ctrl_MULT   <= 1'b0;
         ctrl_DIV    <= 1'b0;
         md_operandA <= '0;
         md_operandB <= '0;
         rd_q        <= '0;
         is_div_q    <= 1'b0;
         wb_reg      <= '0;
         wb_data     <= '0;
      end else begin
         state     <= state_nx;
         ctrl_MULT <= load_op && !ex_aluop[0];
         ctrl_DIV  <= load_op && ex_aluop[0];

         if (state == S_START) begin
            cnt <= '0;
         end else if (state == S_BUSY) begin
            cnt <= cnt + CNT_W'(1);
         end

         if (load_op) begin
            md_operandA <= ex_operandA;
            md_operandB <= ex_operandB;
            rd_q        <= ex_rd;
            is_div_q    <= ex_aluop[0];
         end

         // Writeback fields are resolved on the way into DONE so DONE is a pure strobe.
         if (capture) begin
            wb_reg  <= md_exception ? 5'(STATUS_REG) : rd_q;
            wb_data <= md_exception ? exc_code : md_result;
         end else if (timeout_hit) begin
            wb_reg  <= 5'(STATUS_REG);
            wb_data <= exc_code;
         end
      end
   end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequences the shared multicycle multiplier/divider (multdiv) for mul (opcode 00000, ALU_op 00110) and div (opcode 00000, ALU_op 00111) in the X stage of the 5-stage pipeline.
- Detects a mul/div in X, latches its operands, pulses the multdiv start control and holds a pipeline stall until a result or exception arrives.
- Presents a one-cycle writeback: the result to rd, or the status code to $r30 on exception.

Parameters:
- TIMEOUT, 40, max BUSY cycles to wait for md_resultRDY before forcing an exception
- CNT_W, 6, cycle counter width; must hold TIMEOUT
- MUL_EXC_CODE, 4, value written to $r30 on mul exception or timeout
- DIV_EXC_CODE, 5, value written to $r30 on div exception or timeout
- STATUS_REG, 30, register index for exception writeback

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; returns the block to IDLE
- ex_valid  in  1  X stage holds a valid (non-bubble) instruction
- ex_opcode  in  5  X-stage opcode
- ex_aluop  in  5  X-stage ALU_op field
- ex_rd  in  5  X-stage destination register
- ex_operandA  in  32  rs value after bypass
- ex_operandB  in  32  rt value after bypass
- flush  in  1  kill the X-stage instruction this cycle
- md_resultRDY  in  1  multdiv result valid
- md_exception  in  1  multdiv exception; valid when md_resultRDY=1
- md_result  in  32  multdiv result; valid when md_resultRDY=1
- ctrl_MULT  out  1  one-cycle multiply start pulse (registered)
- ctrl_DIV  out  1  one-cycle divide start pulse (registered)
- md_operandA  out  32  latched operand A, held stable from START to IDLE
- md_operandB  out  32  latched operand B, held stable from START to IDLE
- stall  out  1  freeze PC, F/D and D/X latches; insert bubble into X/M
- busy  out  1  state != IDLE
- wb_valid  out  1  one-cycle writeback strobe
- wb_reg  out  5  writeback register index
- wb_data  out  32  writeback data

Behaviour:
- Reset (asynchronous, active-high, any state): state=IDLE, counter=0. ctrl_MULT, ctrl_DIV, wb_valid, busy = 0. wb_reg, wb_data, md_operandA, md_operandB = 0. Any operation in flight is abandoned with no writeback.
- Detect: is_md = ex_valid & ex_opcode==00000 & ex_aluop in {00110, 00111}.
- stall is combinational: (state==IDLE & is_md & ~flush) | state==START | state==BUSY. It is 0 in DONE.
- IDLE: on is_md & ~flush, latch operands, rd and is_div, then go to START. Otherwise stay in IDLE.
- START (exactly 1 cycle): ctrl_MULT=~is_div, ctrl_DIV=is_div. Clear the counter. Go to BUSY.
- BUSY: counter increments every cycle.
  - On md_resultRDY=1, capture md_result and md_exception, then go to DONE.
  - If counter==TIMEOUT-1 and md_resultRDY=0, set exception=1 and go to DONE.
  - md_resultRDY takes priority over timeout in the same cycle.
- DONE (exactly 1 cycle): wb_valid=1, then go to IDLE.
  - No exception: wb_reg=latched rd, wb_data=captured result.
  - Exception: wb_reg=STATUS_REG, wb_data=DIV_EXC_CODE if is_div, else MUL_EXC_CODE.
  - is_md is ignored in DONE; the same instruction leaves X this cycle.
- flush in START, BUSY or DONE: go to IDLE next cycle. wb_valid is forced to 0 in that cycle. The late multdiv result is ignored. flush has priority over every other transition.
- Latency: detect at T0, START at T1, md_resultRDY sampled at Tn, DONE at Tn+1. stall is high T0..Tn; wb_valid is high at Tn+1.
- md_resultRDY is ignored in IDLE, START and DONE.
- Rd = $r0 writeback is passed through unchanged; the regfile discards it.
- Back-to-back mul/div: the second is detected in the IDLE cycle after DONE, so there is a 1-cycle gap minimum.

Test Plan:
- mul 6*7 into rd=5, RDY at T1+32 -> ctrl_MULT high only at T1; stall high T0..T33; DONE at T34 with wb_valid=1, wb_reg=5, wb_data=42; busy=0 at T35.
- div 100/0 into rd=7, RDY with exception=1 -> wb_reg=30, wb_data=5; ctrl_DIV pulsed once, ctrl_MULT never high.
- mul, RDY never asserted -> DONE exactly TIMEOUT cycles after entering BUSY; wb_reg=30, wb_data=4.
- flush at BUSY cycle 10, then RDY arrives later -> IDLE next cycle, no wb_valid, stall low, late RDY ignored.
- reset asserted mid-BUSY, asynchronous between edges -> all outputs 0 immediately; a later RDY produces no writeback.
- Back-to-back mul then div, with add between them and is_md=0 for add -> two independent writebacks in order with correct data; no spurious ctrl pulse for add.
